// File: rtl/sample_fifo.sv
// sample_fifo
// -----------
// Byte-wide first-word-fall-through FIFO that sits between a sample producer
// and a modulator. The oldest stored byte is always presented on 'sample'
// (8'h00 while empty), so the consumer captures it in the same cycle it
// pulses 'read'. Occupancy status is registered; misuse is recorded in
// sticky overflow/underflow flags until clr_err or rst.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset (highest priority)
//   flush        in   synchronous discard of all stored entries
//   wr_en        in   producer write strobe
//   wr_data[7:0] in   producer sample byte
//   full         out  no free entry
//   almost_full  out  level >= AFULL_LEVEL
//   read         in   consumer pop strobe
//   sample[7:0]  out  oldest stored byte, 8'h00 when empty
//   empty        out  no stored entry
//   level        out  number of stored entries, 0..DEPTH
//   overflow     out  sticky: write refused because FIFO was full
//   underflow    out  sticky: read attempted while empty
//   clr_err      in   clears overflow and underflow
//
// Parameters
//   DEPTH        number of entries, power of two, >= 4
//   AFULL_LEVEL  fill level at or above which almost_full asserts

module sample_fifo #(
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    output logic                       full,
    output logic                       almost_full,
    input  logic                       read,
    output logic [7:0]                 sample,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Storage is deliberately never reset so it maps onto plain RAM.
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          wr_accept;
    logic          rd_accept;
    logic          ovf_event;
    logic          ufl_event;
    logic [LW-1:0] level_next;

    // A write at full is still accepted when a pop frees the slot at the same
    // edge. Flush swallows any concurrent operation without raising errors.
    assign wr_accept = wr_en && (!full || read) && !flush && !rst;
    assign rd_accept = read && !empty && !flush;
    assign ovf_event = wr_en && full && !read && !flush;
    assign ufl_event = read && empty && !flush;

    // Occupancy after the coming edge, used to register the status flags so
    // they match level exactly.
    always_comb begin
        level_next = level;
        case ({wr_accept, rd_accept})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    // RAM write port.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, level and registered status flags.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level       <= level_next;
            empty       <= (level_next == '0);
            full        <= (level_next == LW'(DEPTH));
            almost_full <= (int'(level_next) >= AFULL_LEVEL);
        end
    end

    // Sticky error flags; a new event wins over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  && !clr_err) || ovf_event;
            underflow <= (underflow && !clr_err) || ufl_event;
        end
    end

    // First-word-fall-through output: asynchronous read of the head entry.
    assign sample = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: doc/sample_fifo.md
SAMPLE_FIFO -- requirements
Module: sample_fifo

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 16, number of 8-bit entries; power of two, >= 4.
REQ-002 The block SHALL provide parameter AFULL_LEVEL, default DEPTH-2, fill level at or above which almost_full asserts.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  synchronous discard of all stored entries.
REQ-006 wr_en  input  1  producer write strobe.
REQ-007 wr_data  input  8  producer sample byte.
REQ-008 full  output  1  no free entry.
REQ-009 almost_full  output  1  level >= AFULL_LEVEL.
REQ-010 read  input  1  consumer pop strobe, modulator side.
REQ-011 sample  output  8  oldest stored byte (first-word-fall-through).
REQ-012 empty  output  1  no stored entry.
REQ-013 level  output  $clog2(DEPTH)+1  current number of stored entries.
REQ-014 overflow  output  1  sticky: write attempted while full and not accepted.
REQ-015 underflow  output  1  sticky: read attempted while empty.
REQ-016 clr_err  input  1  clears overflow and underflow.

Function
REQ-017 sample SHALL present the oldest entry whenever empty=0, with no read-request latency; the consumer captures sample in the same cycle it asserts read.
REQ-018 sample SHALL be 8'h00 whenever empty=1.
REQ-019 A read with empty=0 SHALL pop one entry at the clock edge; the next entry (or 8'h00 if none) SHALL appear on sample in the following cycle.
REQ-020 A write with full=0 SHALL store wr_data at the edge; the byte SHALL be visible on sample in the next cycle if the FIFO was empty.
REQ-021 full, empty, almost_full and level SHALL be registered and reflect occupancy after the most recent edge.
REQ-022 Write and read pointers SHALL be $clog2(DEPTH) bits, increment by one per accepted operation and wrap DEPTH-1 -> 0.
REQ-023 level SHALL equal accepted writes minus accepted pops since the last reset or flush, range 0..DEPTH.
REQ-024 Simultaneous write and read with 0 < level < DEPTH: both accepted, level unchanged.
REQ-025 Simultaneous write and read at level = DEPTH: both accepted, level stays DEPTH, full stays 1.
REQ-026 Simultaneous write and read at level = 0: write accepted, read ignored, underflow set, level -> 1.
REQ-027 A write at full=1 without a simultaneous read SHALL be dropped, contents unchanged, overflow set.
REQ-028 A read at empty=1 SHALL be ignored and set underflow.
REQ-029 overflow and underflow SHALL remain 1 until clr_err or rst; if clr_err coincides with a new error event, the flag SHALL read 1 after the edge.
REQ-030 flush SHALL zero pointers and level, set empty=1, full=0, almost_full=0; any write or read in the same cycle SHALL be ignored without error flags; overflow/underflow SHALL be unaffected.
REQ-031 Storage SHALL be inferable block/distributed RAM; memory contents SHALL not be reset.

Reset
REQ-032 rst=1 SHALL at the edge force pointers=0, level=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0, sample=8'h00.
REQ-033 rst SHALL take priority over flush, clr_err, wr_en and read; reset mid-stream SHALL discard all stored data.

Verification
REQ-034 Reset, write 8'hA5 once -> next cycle empty=0, sample=8'hA5, level=1; read once -> next cycle empty=1, sample=8'h00.
REQ-035 DEPTH=16: write 16 bytes 8'h00..8'h0F -> almost_full=1 at level 14, full=1 at level 16; 17th write 8'hFF -> dropped, overflow=1; 16 reads return 8'h00..8'h0F in order.
REQ-036 At level=16 assert wr_en and read together with wr_data=8'h55 -> sample advances to next byte, level stays 16, overflow stays 0; 8'h55 emerges last.
REQ-037 Drive 40 write/read pairs at steady level 3 -> pointers wrap twice, output order matches input order, no error flags.
REQ-038 At level=0 assert read and wr_en (8'h3C) together -> underflow=1, level=1, sample=8'h3C; then clr_err -> underflow=0.
REQ-039 At level=5 assert flush with wr_en=1 -> level=0, empty=1, no error flag; assert rst at level=7 -> all outputs at REQ-032 values next cycle.
